// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   - RV32I load/store funct3 width codes
//   - FSM state encoding for the data-memory handshake
package mem_access_stage_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// load_formatter: combinational load-data alignment and extension.
// Shared with the writeback forwarding path.
//   rdata   in  32  raw word from data memory
//   offset  in  2   byte offset of the access within the word
//   funct3  in  3   RV32I load width/sign code
//   result  out 32  aligned, sign- or zero-extended load value
module load_formatter
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic signed [7:0]  byte_sel;
   logic signed [15:0] half_sel;

   always_comb begin
      byte_sel = 8'sd0;
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

      result = rdata;
      case (funct3)
         F3_B:    result = 32'(byte_sel);            // signed source: sign-extends
         F3_H:    result = 32'(half_sel);
         F3_BU:   result = {24'd0, byte_sel};
         F3_HU:   result = {16'd0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I MEM stage. Converts an EX/MEM load/store into a
// req/ready + rvalid data-memory transaction, formats load data for MEM_WB,
// stalls the front of the pipe while the transaction is outstanding, and
// reports misaligned / illegal accesses without issuing a request.
//   clk, reset (async, active-low)
//   mem_valid/mem_read/mem_write/mem_funct3/mem_addr/mem_store_data : EX/MEM
//   stall, read_data, access_fault                                   : pipeline
//   dmem_req/we/addr/be/wdata (out), dmem_ready/rvalid/rdata (in)    : memory
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        mem_funct3,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       mem_store_data,
   output logic              stall,
   output logic [31:0]       read_data,
   output logic              access_fault,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [3:0]        dmem_be,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_ready,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata
);

   state_t      state;
   logic        op;
   logic        illegal;
   logic        misaligned;
   logic        fault;
   logic        legal_op;
   logic [1:0]  off_q;
   logic [2:0]  f3_q;
   logic [31:0] fmt_data;

   // funct3[1:0] encodes width for both signed and unsigned variants.
   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   lane_be = 4'b0001 << off;
         2'b01:   lane_be = 4'b0011 << off;
         default: lane_be = 4'b1111;
      endcase
   endfunction

   // Replicate the store value across every lane it could land in so the
   // byte enables alone select the destination.
   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] data);
      case (f3[1:0])
         2'b00:   lane_wdata = {4{data[7:0]}};
         2'b01:   lane_wdata = {2{data[15:0]}};
         default: lane_wdata = data;
      endcase
   endfunction

   always_comb begin
      op      = mem_valid & (mem_read | mem_write);
      illegal = mem_read & mem_write;
      case (mem_funct3)
         F3_B, F3_H, F3_W: ;
         F3_BU, F3_HU:     illegal = illegal | mem_write;
         default:          illegal = 1'b1;
      endcase
      misaligned = ((mem_funct3 == F3_H || mem_funct3 == F3_HU) && mem_addr[0]) ||
                   ((mem_funct3 == F3_W) && (mem_addr[1:0] != 2'b00));
      fault    = op & (illegal | misaligned);
      legal_op = op & ~fault;
   end

   // Gated by reset so the pipeline is never held while the stage is in reset.
   assign stall = reset & ((state == ST_IDLE && legal_op) ||
                           state == ST_REQ || state == ST_RESP);

   load_formatter u_fmt (
      .rdata  (dmem_rdata),
      .offset (off_q),
      .funct3 (f3_q),
      .result (fmt_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         read_data    <= 32'd0;
         access_fault <= 1'b0;
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_be      <= 4'd0;
         dmem_wdata   <= 32'd0;
         off_q        <= 2'd0;
         f3_q         <= 3'd0;
      end else begin
         access_fault <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (fault) begin
                  access_fault <= 1'b1;
               end else if (legal_op) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= mem_write;
                  dmem_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                  dmem_be    <= lane_be(mem_funct3, mem_addr[1:0]);
                  dmem_wdata <= lane_wdata(mem_funct3, mem_store_data);
                  off_q      <= mem_addr[1:0];
                  f3_q       <= mem_funct3;
                  state      <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  state    <= dmem_we ? ST_DONE : ST_RESP;
               end
            end
            ST_RESP: begin
               if (dmem_rvalid) begin
                  read_data <= fmt_data;
                  state     <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   localparam int K_REQ   = 0;
   localparam int K_READ  = 1;
   localparam int K_FAULT = 2;

   typedef struct {
      int          kind;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  mem_funct3 = 3'd0;
   logic [31:0] mem_addr = 32'd0, mem_store_data = 32'd0;
   logic        stall, access_fault, dmem_req, dmem_we;
   logic [31:0] read_data, dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   mem_access_stage dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_store_data(mem_store_data),
      .stall(stall), .read_data(read_data), .access_fault(access_fault),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
      .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push(input int kind, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
      exp_t e;
      e.kind = kind; e.we = we; e.addr = addr; e.be = be; e.data = data;
      sbq.push_back(e);
   endtask

   task automatic pop(output exp_t e, output bit ok);
      ok = (sbq.size() != 0);
      if (ok) e = sbq.pop_front();
      else begin
         total++; bad++;
         $display("FAIL unexpected_output: got event with empty scoreboard want none");
      end
   endtask

   // Monitor: pops and compares whenever the DUT presents a transaction.
   initial begin
      exp_t e;
      bit   ok;
      bit   pend, chk_next;
      pend = 0; chk_next = 0;
      forever begin
         @(negedge clk); #3;
         if (!reset) begin
            pend = 0; chk_next = 0;
         end else begin
            if (chk_next) begin
               chk_next = 0;
               pop(e, ok);
               if (ok) begin
                  chk("read_kind", 32'(e.kind), 32'(K_READ));
                  chk("read_data", read_data, e.data);
               end
            end
            if (pend && dmem_rvalid) begin
               pend = 0; chk_next = 1;
            end
            if (access_fault) begin
               pop(e, ok);
               if (ok) chk("fault_kind", 32'(e.kind), 32'(K_FAULT));
            end
            if (dmem_req && dmem_ready) begin
               pop(e, ok);
               if (ok) begin
                  chk("req_kind", 32'(e.kind), 32'(K_REQ));
                  chk("req_addr", dmem_addr, e.addr);
                  chk("req_we", 32'(dmem_we), 32'(e.we));
                  if (e.we) begin
                     chk("req_be", 32'(dmem_be), 32'(e.be));
                     chk("req_wdata", dmem_wdata, e.data);
                  end else pend = 1;
               end
            end
         end
      end
   end

   // One legal transaction: plays the memory side and counts stall cycles.
   task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int ready_wait, input int rvalid_wait,
                         input logic [31:0] rdata, input int exp_stall);
      int          stall_cnt, req_cyc, resp_cyc;
      bit          accepted, done, stable;
      logic [31:0] a0, w0;
      logic [3:0]  b0;
      logic        we0;
      stall_cnt = 0; req_cyc = 0; resp_cyc = 0;
      accepted = 0; done = 0; stable = 1;
      a0 = 0; w0 = 0; b0 = 0; we0 = 0;
      @(negedge clk);
      mem_valid = 1; mem_read = rd; mem_write = wr; mem_funct3 = f3;
      mem_addr = addr; mem_store_data = data;
      for (int c = 0; c < 40 && !done; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 32'd0;
         if (!stall) done = 1;
         else begin
            stall_cnt++;
            if (dmem_req) begin
               if (req_cyc == 0) begin
                  a0 = dmem_addr; b0 = dmem_be; w0 = dmem_wdata; we0 = dmem_we;
               end else if (dmem_addr !== a0 || dmem_be !== b0 ||
                            dmem_wdata !== w0 || dmem_we !== we0) stable = 0;
               if (req_cyc >= ready_wait) begin
                  dmem_ready = 1; accepted = 1;
               end
               req_cyc++;
            end else if (accepted) begin
               if (resp_cyc >= rvalid_wait) begin
                  dmem_rvalid = 1; dmem_rdata = rdata;
               end
               resp_cyc++;
            end
         end
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL op_timeout: got stall still high want completion within 40 cycles");
      end
      chk("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
      chk("req_stable", 32'(stable), 32'd1);
      @(negedge clk);
      mem_valid = 0; mem_read = 0; mem_write = 0;
   endtask

   // Faulting access(es) presented on n consecutive cycles.
   task automatic fault_op(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input int n);
      int af_cnt, req_cnt, st_cnt;
      af_cnt = 0; req_cnt = 0; st_cnt = 0;
      for (int i = 0; i < n; i++) push(K_FAULT, 0, 0, 0, 0);
      @(negedge clk);
      mem_valid = 1; mem_read = rd; mem_write = wr; mem_funct3 = f3; mem_addr = addr;
      for (int i = 0; i < n + 4; i++) begin
         if (i > 0) @(negedge clk);
         if (i == n) begin mem_valid = 0; mem_read = 0; mem_write = 0; end
         #1;
         if (access_fault) af_cnt++;
         if (dmem_req) req_cnt++;
         if (stall) st_cnt++;
      end
      chk("fault_pulses", 32'(af_cnt), 32'(n));
      chk("fault_no_req", 32'(req_cnt), 32'd0);
      chk("fault_stall", 32'(st_cnt), 32'd0);
   endtask

   initial begin
      logic [31:0] saved;
      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_fault", 32'(access_fault), 32'd0);
      chk("rst_req_we", {30'd0, dmem_req, dmem_we}, 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_be_wdata", dmem_wdata | 32'(dmem_be), 32'd0);
      @(negedge clk); reset = 1;

      // Stores
      push(K_REQ, 1, 32'h104, 4'b1111, 32'hDEADBEEF);
      run_op(0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0, 2);
      push(K_REQ, 1, 32'h100, 4'b1000, 32'hA5A5A5A5);
      run_op(0, 1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 2);
      push(K_REQ, 1, 32'h100, 4'b1100, 32'hABCDABCD);
      run_op(0, 1, 3'b001, 32'h102, 32'h1234ABCD, 0, 0, 0, 2);

      // Loads
      push(K_REQ, 0, 32'h200, 0, 0); push(K_READ, 0, 0, 0, 32'hFFFFFFF4);
      run_op(1, 0, 3'b000, 32'h202, 0, 0, 2, 32'h12F45678, 5);
      push(K_REQ, 0, 32'h200, 0, 0); push(K_READ, 0, 0, 0, 32'h000000F4);
      run_op(1, 0, 3'b100, 32'h202, 0, 0, 2, 32'h12F45678, 5);
      push(K_REQ, 0, 32'h200, 0, 0); push(K_READ, 0, 0, 0, 32'h000012F4);
      run_op(1, 0, 3'b101, 32'h202, 0, 0, 0, 32'h12F45678, 3);
      push(K_REQ, 0, 32'h200, 0, 0); push(K_READ, 0, 0, 0, 32'hFFFF8001);
      run_op(1, 0, 3'b001, 32'h200, 0, 0, 0, 32'h00008001, 3);

      // Store leaves read_data alone; stray rvalid in IDLE is ignored
      push(K_REQ, 1, 32'h108, 4'b1111, 32'h00000001);
      run_op(0, 1, 3'b010, 32'h108, 32'h00000001, 0, 0, 0, 2);
      chk("rd_hold_store", read_data, 32'hFFFF8001);
      @(negedge clk); #1; dmem_rvalid = 1; dmem_rdata = 32'h55555555;
      @(negedge clk); #1; dmem_rvalid = 0;
      chk("rd_hold_rvalid", read_data, 32'hFFFF8001);

      // Faults
      fault_op(1, 0, 3'b001, 32'h201, 1);
      fault_op(1, 0, 3'b011, 32'h200, 1);
      fault_op(0, 1, 3'b010, 32'h102, 1);
      fault_op(0, 1, 3'b100, 32'h100, 1);
      fault_op(1, 1, 3'b010, 32'h200, 1);
      fault_op(1, 0, 3'b010, 32'h203, 2);
      chk("rd_hold_fault", read_data, 32'hFFFF8001);

      // Ready held low 4 cycles
      push(K_REQ, 0, 32'h300, 0, 0); push(K_READ, 0, 0, 0, 32'hCAFEF00D);
      run_op(1, 0, 3'b010, 32'h300, 0, 4, 0, 32'hCAFEF00D, 7);

      // Reset during RESP
      saved = read_data;
      push(K_REQ, 0, 32'h400, 0, 0);
      @(negedge clk);
      mem_valid = 1; mem_read = 1; mem_write = 0; mem_funct3 = 3'b010; mem_addr = 32'h400;
      @(negedge clk); #1; dmem_ready = 1;
      @(negedge clk); #1; dmem_ready = 0;
      chk("resp_stall", 32'(stall), 32'd1);
      reset = 0; #1;
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_req", {30'd0, dmem_req, dmem_we}, 32'd0);
      chk("mid_rst_read_data", read_data | (saved & 32'd0), 32'd0);
      chk("mid_rst_fields", dmem_addr | dmem_wdata | 32'(dmem_be) | 32'(access_fault), 32'd0);
      mem_valid = 0; mem_read = 0;
      @(negedge clk); reset = 1;
      #1; dmem_rvalid = 1; dmem_rdata = 32'h77777777;
      @(negedge clk); #1; dmem_rvalid = 0;
      chk("late_rvalid_ignored", read_data, 32'd0);
      chk("late_rvalid_stall", 32'(stall), 32'd0);
      push(K_REQ, 0, 32'h500, 0, 0); push(K_READ, 0, 0, 0, 32'h0BADF00D);
      run_op(1, 0, 3'b010, 32'h500, 0, 0, 0, 32'h0BADF00D, 3);

      repeat (4) @(negedge clk);
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
